// File: rtl/block_mem_responder.sv
// Serialises 256-bit block reads/writes from the processor into eight
// sequential accesses on a single-port 32-bit synchronous word RAM.
module block_mem_responder #(
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int BLOCK_ADDR_W    = 11,
  localparam int IDX_W          = $clog2(WORDS_PER_BLOCK),
  localparam int BLOCK_W        = WORD_W * WORDS_PER_BLOCK,
  localparam int RAM_ADDR_W     = BLOCK_ADDR_W + IDX_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [BLOCK_ADDR_W-1:0] io_memAdrrs,
  input  logic                    io_memRead,
  input  logic                    io_memWrite,
  input  logic [BLOCK_W-1:0]      io_memWriteBlock,
  output logic [BLOCK_W-1:0]      io_memReadBlock,
  output logic                    io_memReady,
  output logic [RAM_ADDR_W-1:0]   ram_addr,
  output logic [WORD_W-1:0]       ram_wdata,
  output logic                    ram_we,
  input  logic [WORD_W-1:0]       ram_rdata,
  output logic [1:0]              dbgState
);

  // Handshake: io_memRead/io_memWrite are level requests sampled only in IDLE
  // (write wins); io_memReady pulses for one cycle when the block is complete,
  // and the processor must have dropped its strobe by that cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t stateNext;
  logic   accept;
  logic   lastWord;

  logic [BLOCK_ADDR_W-1:0] addrQ;
  logic [IDX_W-1:0]        idx;
  logic [WORD_W-1:0]       wordsQ [WORDS_PER_BLOCK];
  logic                    drainQ;
  logic                    capValidQ;
  logic [IDX_W-1:0]        capIdxQ;
  logic [BLOCK_W-1:0]      readBlockQ;

  assign lastWord        = (idx == IDX_W'(WORDS_PER_BLOCK - 1));
  assign io_memReadBlock = readBlockQ;
  assign dbgState        = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Outputs decode straight from state so a reset drops ram_we without an edge.
  always_comb begin
    stateNext   = state;
    accept      = 1'b0;
    io_memReady = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    case (state)
      IDLE: begin
        if (io_memWrite) begin
          stateNext = WRITE;
          accept    = 1'b1;
        end else if (io_memRead) begin
          stateNext = READ;
          accept    = 1'b1;
        end
      end
      WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = {addrQ, idx};
        ram_wdata = wordsQ[idx];
        if (lastWord) stateNext = DONE;
      end
      READ: begin
        ram_addr = {addrQ, idx};
        if (drainQ && capValidQ) stateNext = DONE;
      end
      DONE: begin
        io_memReady = 1'b1;
        stateNext   = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Read data trails its address by one edge, so the captured word index is
  // pipelined alongside; drainQ holds READ open until the last word lands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addrQ      <= '0;
      idx        <= '0;
      drainQ     <= 1'b0;
      capValidQ  <= 1'b0;
      capIdxQ    <= '0;
      readBlockQ <= '0;
      for (int k = 0; k < WORDS_PER_BLOCK; k++) wordsQ[k] <= '0;
    end else begin
      capValidQ <= 1'b0;
      if (accept) begin
        addrQ  <= io_memAdrrs;
        idx    <= '0;
        drainQ <= 1'b0;
        for (int k = 0; k < WORDS_PER_BLOCK; k++)
          wordsQ[k] <= io_memWriteBlock[k*WORD_W +: WORD_W];
      end else if (state == WRITE) begin
        idx <= idx + IDX_W'(1);
      end else if (state == READ && !drainQ) begin
        capValidQ <= 1'b1;
        capIdxQ   <= idx;
        if (lastWord) drainQ <= 1'b1;
        else          idx    <= idx + IDX_W'(1);
      end
      if (capValidQ) begin
        for (int k = 0; k < WORDS_PER_BLOCK; k++)
          if (capIdxQ == IDX_W'(k)) readBlockQ[k*WORD_W +: WORD_W] <= ram_rdata;
      end
    end
  end

endmodule
